// File: rtl/threshold_pkg.sv
// Shared types and sizing helpers for the serial weighted-threshold scheduler.
package threshold_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Sum width that cannot overflow: full product plus log2(inputs) guard bits.
  function automatic int acc_width(input int w, input int n_in);
    return 2 * w + $clog2(n_in);
  endfunction

  function automatic int th_addr(input int n_in);
    return n_in;
  endfunction

endpackage

// File: rtl/threshold_mac.sv
// Shared signed multiply-accumulate unit; acc_next exposes the sum including the current term.
module threshold_mac #(
  parameter int W = 32,
  parameter int ACC_W = 66
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] acc_next
);

  logic signed [2*W-1:0] prod;

  assign prod     = a * b;
  assign acc_next = acc + {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/threshold_seq_ctrl.sv
// Serial scheduler for an N-input weighted threshold gate: one MAC shared across inputs.
//   state | meaning
//   IDLE  | ready for a vector; config writes accepted
//   MAC   | one term per cycle, idx = 0..N_IN-1
//   DONE  | result held on out_f/out_sum until out_ready
module threshold_seq_ctrl
  import threshold_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W = 32,
  localparam int ACC_W = acc_width(W, N_IN),
  localparam int AW = $clog2(N_IN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [W-1:0]      cfg_wdata,
  output logic              cfg_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN*W-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_f,
  output logic [ACC_W-1:0]  out_sum
);

  localparam int IDX_W = $clog2(N_IN);
  localparam logic [AW-1:0] TH_ADDR = AW'(th_addr(N_IN));

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic signed [W-1:0]     w_cfg  [N_IN];
  logic signed [W-1:0]     th_cfg;
  logic signed [W-1:0]     w_snap [N_IN];
  logic signed [W-1:0]     th_snap;
  logic signed [W-1:0]     x_reg  [N_IN];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] th_ext;
  logic                    accept;

  assign accept = (state == IDLE) && in_valid;
  assign th_ext = {{(ACC_W - W){th_snap[W-1]}}, th_snap};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) w_cfg[i] <= '0;
      th_cfg <= '0;
    end else if (cfg_we && state == IDLE) begin
      if (cfg_addr == TH_ADDR) begin
        th_cfg <= cfg_wdata;
      end else if (cfg_addr < TH_ADDR) begin
        w_cfg[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
      end
    end
  end

  // Weights and threshold are snapshotted at accept so a same-cycle config write
  // only affects the following vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cfg_busy  <= 1'b0;
      out_f     <= 1'b0;
      out_sum   <= '0;
      th_snap   <= '0;
      for (int i = 0; i < N_IN; i++) begin
        x_reg[i]  <= '0;
        w_snap[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= x[i*W +: W];
            w_snap   <= w_cfg;
            th_snap  <= th_cfg;
            idx      <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            cfg_busy <= 1'b1;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (idx == IDX_W'(N_IN - 1)) begin
            idx       <= '0;
            out_sum   <= acc_next;
            out_f     <= (acc_next >= th_ext);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            cfg_busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

  threshold_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .en       (state == MAC),
    .a        (x_reg[idx]),
    .b        (w_snap[idx]),
    .acc      (acc),
    .acc_next (acc_next)
  );

endmodule

// File: tb/tb_threshold_seq_ctrl.sv
// Bench for threshold_seq_ctrl (N_IN=4, W=32): vector table, corner sequences, random vs sum model.
module tb_threshold_seq_ctrl;

  localparam int N = 4;
  localparam int W = 32;
  localparam int AW = 3;
  localparam int ACC = 66;

  logic           clk = 1'b0;
  logic           rst_n, cfg_we, in_valid, out_ready;
  logic [AW-1:0]  cfg_addr;
  logic [W-1:0]   cfg_wdata;
  logic [N*W-1:0] x;
  logic           cfg_busy, in_ready, out_valid, out_f;
  logic [ACC-1:0] out_sum;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] mw [N];
  logic signed [W-1:0] mth;

  typedef struct {
    logic signed [W-1:0] th;
    logic [N*W-1:0]      xv;
    logic                f;
    logic [ACC-1:0]      sum;
  } vec_t;
  vec_t tbl [8];

  threshold_seq_ctrl #(.N_IN(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_sum(out_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [ACC-1:0] got, input logic [ACC-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: plain signed dot product of the vector with the model weights.
  function automatic logic signed [ACC-1:0] ref_sum(input logic [N*W-1:0] xv);
    logic signed [ACC-1:0] s, a, b;
    s = '0;
    for (int i = 0; i < N; i++) begin
      a = $signed(xv[i*W +: W]);
      b = mw[i];
      s = s + a * b;
    end
    return s;
  endfunction

  function automatic logic ref_f(input logic signed [ACC-1:0] s);
    logic signed [ACC-1:0] t;
    t = mth;
    return s >= t;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    logic signed [W-1:0] v;
    if ($urandom_range(1) == 0) v = $signed(W'($urandom_range(40))) - 20;
    else v = $urandom;
    return v;
  endfunction

  function automatic logic [N*W-1:0] rnd_vec();
    return pack4(rnd_val(), rnd_val(), rnd_val(), rnd_val());
  endfunction

  task automatic cfg_write(input logic [AW-1:0] a, input logic [W-1:0] d, input bit upd);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (upd && a < AW'(N)) mw[a[1:0]] = d;
    else if (upd && a == AW'(N)) mth = d;
  endtask

  task automatic start_vec(input logic [N*W-1:0] xv);
    @(negedge clk);
    in_valid = 1'b1; x = xv;
    @(negedge clk);
    in_valid = 1'b0; x = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_result(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk({name, " timeout"}, ACC'(0), ACC'(1));
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [N*W-1:0] xv);
    logic signed [ACC-1:0] es;
    logic ef;
    int lat;
    es = ref_sum(xv);
    ef = ref_f(es);
    start_vec(xv);
    wait_result(name, lat);
    chk({name, " sum"}, out_sum, es);
    chk({name, " f"}, ACC'(out_f), ACC'(ef));
    accept_out();
  endtask

  initial begin
    logic signed [ACC-1:0] es;
    logic ef;
    int lat;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; out_ready = 1'b0; x = '0;
    for (int i = 0; i < N; i++) mw[i] = '0;
    mth = '0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", ACC'(in_ready), ACC'(1));
    chk("rst out_valid", ACC'(out_valid), ACC'(0));
    chk("rst out_f", ACC'(out_f), ACC'(0));
    chk("rst out_sum", out_sum, ACC'(0));
    chk("rst cfg_busy", ACC'(cfg_busy), ACC'(0));
    rst_n = 1'b1;

    // AND then OR gate on inputs 0/1; lanes 2/3 carry noise under zero weight.
    tbl[0] = '{32'sd2, pack4(0, 0, 0, 0), 1'b0, 66'd0};
    tbl[1] = '{32'sd2, pack4(0, 1, 0, 0), 1'b0, 66'd1};
    tbl[2] = '{32'sd2, pack4(1, 0, 0, 0), 1'b0, 66'd1};
    tbl[3] = '{32'sd2, pack4(1, 1, 0, 0), 1'b1, 66'd2};
    tbl[4] = '{32'sd1, pack4(0, 0, 0, 0), 1'b0, 66'd0};
    tbl[5] = '{32'sd1, pack4(0, 1, 0, 0), 1'b1, 66'd1};
    tbl[6] = '{32'sd1, pack4(1, 0, 0, 0), 1'b1, 66'd1};
    tbl[7] = '{32'sd1, pack4(1, 1, 0, 0), 1'b1, 66'd2};
    cfg_write(3'd0, 32'd1, 1'b1);
    cfg_write(3'd1, 32'd1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tbl[i].xv[N*W-1:2*W] = {$urandom, $urandom};
      cfg_write(3'd4, tbl[i].th, 1'b1);
      start_vec(tbl[i].xv);
      wait_result("tbl", lat);
      chk($sformatf("tbl%0d sum", i), out_sum, tbl[i].sum);
      chk($sformatf("tbl%0d f", i), ACC'(out_f), ACC'(tbl[i].f));
      accept_out();
    end

    // Mixed-sign weights, latency exactly N cycles.
    cfg_write(3'd0, -32'sd3, 1'b1);
    cfg_write(3'd1, 32'sd5, 1'b1);
    cfg_write(3'd2, 32'sd2, 1'b1);
    cfg_write(3'd3, -32'sd1, 1'b1);
    cfg_write(3'd4, 32'sd0, 1'b1);
    start_vec(pack4(1, 1, 1, 1));
    wait_result("mixed", lat);
    chk("mixed sum", out_sum, ACC'(3));
    chk("mixed f", ACC'(out_f), ACC'(1));
    chk("mixed latency", ACC'(lat), ACC'(N));
    accept_out();

    // DONE held with out_ready low; in_valid pulses must be ignored.
    es = ref_sum(pack4(2, 0, 0, 0));
    ef = ref_f(es);
    start_vec(pack4(2, 0, 0, 0));
    wait_result("hold", lat);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0]; x = rnd_vec();
      @(negedge clk);
      chk("hold out_valid", ACC'(out_valid), ACC'(1));
      chk("hold sum", out_sum, es);
      chk("hold f", ACC'(out_f), ACC'(ef));
      chk("hold in_ready", ACC'(in_ready), ACC'(0));
    end
    in_valid = 1'b0;
    accept_out();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no queued out_valid", ACC'(out_valid), ACC'(0));
      chk("idle in_ready", ACC'(in_ready), ACC'(1));
    end

    // Config write during MAC is dropped.
    es = ref_sum(pack4(7, 1, 1, 1));
    start_vec(pack4(7, 1, 1, 1));
    cfg_write(3'd0, 32'd100, 1'b0);
    wait_result("mac write", lat);
    chk("mac write sum", out_sum, es);
    accept_out();
    run_check("mac write after", pack4(1, 0, 0, 0));

    // Out-of-range addresses are ignored.
    cfg_write(3'd5, 32'd77, 1'b0);
    cfg_write(3'd7, 32'd77, 1'b0);
    run_check("bad addr", pack4(3, 4, 5, 6));

    // Same-cycle write and accept: this vector uses the old w1, the next one the new.
    es = ref_sum(pack4(0, 2, 0, 0));
    @(negedge clk);
    in_valid = 1'b1; x = pack4(0, 2, 0, 0);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'd9;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    mw[1] = 32'd9;
    wait_result("same cycle", lat);
    chk("same cycle sum", out_sum, es);
    accept_out();
    run_check("same cycle next", pack4(0, 2, 0, 0));

    // Random configuration and vectors, with random consumer stall.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1) == 1) cfg_write(AW'($urandom_range(7)), rnd_val(), 1'b1);
      es = ref_sum(x);
      es = ref_sum(rnd_vec());
      x = rnd_vec();
      begin
        logic [N*W-1:0] xv;
        xv = rnd_vec();
        es = ref_sum(xv);
        ef = ref_f(es);
        start_vec(xv);
        wait_result("rand", lat);
        repeat ($urandom_range(3)) @(negedge clk);
        chk("rand sum", out_sum, es);
        chk("rand f", ACC'(out_f), ACC'(ef));
        accept_out();
      end
    end

    // Reset mid-MAC discards the result and clears configuration.
    start_vec(pack4(5, 5, 5, 5));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) mw[i] = '0;
    mth = '0;
    chk("mid rst in_ready", ACC'(in_ready), ACC'(1));
    chk("mid rst out_valid", ACC'(out_valid), ACC'(0));
    chk("mid rst out_sum", out_sum, ACC'(0));
    repeat (5) @(negedge clk);
    chk("mid rst no pulse", ACC'(out_valid), ACC'(0));
    start_vec(pack4(0, 0, 0, 0));
    wait_result("post rst", lat);
    chk("post rst f", ACC'(out_f), ACC'(1));
    chk("post rst sum", out_sum, ACC'(0));
    accept_out();
    run_check("post rst rand", rnd_vec());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
